change_dispenser: RTL and testbench

//  Downstream of the vending FSM: takes the change/refund amount it produces and pays it
//  out as physical coins (20/10/5) through a hopper with a valid/ack handshake.

---
 rtl/change_dispenser.sv | 214 +++++++++++++++++++++
 tb/tb_change_dispenser.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin payout controller: pays an owed amount as 20/10/5 coins, largest coin first, via a hopper handshake.
// Optional LOW_COIN_WARN_EN macro enables a registered low-tube warning on low_coin.
module change_dispenser #(
  parameter int INIT_CNT    = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
`ifdef LOW_COIN_WARN_EN
  , parameter int LOW_THRESH = 2
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       change_req,
  input  logic [7:0] change_amt,
  input  logic       hopper_ack,
  input  logic       refill,
  input  logic [1:0] refill_coin,
  input  logic       jam_clr,
  output logic       eject_valid,
  output logic [1:0] eject_coin,
  output logic       busy,
  output logic       done,
  output logic       short_change,
  output logic [7:0] short_amt,
  output logic       jam,
  output logic       low_coin
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE, S_JAM} state_t;

  localparam logic [1:0] C5  = 2'b01;
  localparam logic [1:0] C10 = 2'b10;
  localparam logic [1:0] C20 = 2'b11;
  localparam logic [3:0] CNT_INIT = 4'(INIT_CNT);
  localparam logic [7:0] ACK_LOAD = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     r_state;
  logic [7:0] r_rem;
  logic [7:0] r_timer;
  logic [3:0] r_cnt5, r_cnt10, r_cnt20;
  logic       r_ev;
  logic [1:0] r_coin;
  logic       r_busy, r_done, r_short, r_jam;
  logic [7:0] r_samt;

  logic [1:0] w_sel;
  logic       w_ack_take;
  logic       w_req_nz;
  logic [7:0] w_rem_base;
  logic [8:0] w_rem_sum;
  logic [7:0] w_rem_upd;

  function automatic logic [7:0] coin_value(input logic [1:0] c);
    case (c)
      C5:      coin_value = 8'd5;
      C10:     coin_value = 8'd10;
      C20:     coin_value = 8'd20;
      default: coin_value = 8'd0;
    endcase
  endfunction

  function automatic logic [3:0] tube_next(input logic [3:0] cnt, input logic inc,
                                           input logic dec);
    if (inc && !dec && cnt != 4'd15)      tube_next = cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0)  tube_next = cnt - 4'd1;
    else                                  tube_next = cnt;
  endfunction

  always_comb begin
    w_sel = 2'b00;
    if (r_rem >= 8'd20 && r_cnt20 != 4'd0)      w_sel = C20;
    else if (r_rem >= 8'd10 && r_cnt10 != 4'd0) w_sel = C10;
    else if (r_rem >= 8'd5 && r_cnt5 != 4'd0)   w_sel = C5;
  end

  // Owed amount after this cycle's accepted coin and any new request (saturating).
  assign w_ack_take = (r_state == S_EJECT) && hopper_ack;
  assign w_req_nz   = change_req && (change_amt != 8'd0);
  assign w_rem_base = w_ack_take ? (r_rem - coin_value(r_coin)) : r_rem;
  assign w_rem_sum  = {1'b0, w_rem_base} + {1'b0, change_amt};
  assign w_rem_upd  = !change_req ? w_rem_base : (w_rem_sum[8] ? 8'hFF : w_rem_sum[7:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt5  <= CNT_INIT;
      r_cnt10 <= CNT_INIT;
      r_cnt20 <= CNT_INIT;
    end else begin
      r_cnt5  <= tube_next(r_cnt5,  refill && refill_coin == C5,  w_ack_take && r_coin == C5);
      r_cnt10 <= tube_next(r_cnt10, refill && refill_coin == C10, w_ack_take && r_coin == C10);
      r_cnt20 <= tube_next(r_cnt20, refill && refill_coin == C20, w_ack_take && r_coin == C20);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= 8'd0;
      r_timer <= 8'd0;
      r_ev    <= 1'b0;
      r_coin  <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_short <= 1'b0;
      r_samt  <= 8'd0;
      r_jam   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_short <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_nz) begin
            r_rem   <= change_amt;
            r_busy  <= 1'b1;
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          r_rem <= w_rem_upd;
          if (w_sel != 2'b00) begin
            r_ev    <= 1'b1;
            r_coin  <= w_sel;
            r_timer <= ACK_LOAD;
            r_state <= S_EJECT;
          end else if (w_req_nz) begin
            // New money arrived: re-evaluate next cycle rather than finishing or shorting.
            r_state <= S_SELECT;
          end else if (r_rem == 8'd0) begin
            r_state <= S_DONE;
          end else begin
            r_short <= 1'b1;
            r_samt  <= r_rem;
            r_rem   <= 8'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_EJECT: begin
          r_rem <= w_rem_upd;
          if (hopper_ack) begin
            r_ev   <= 1'b0;
            r_coin <= 2'b00;
            if (GAP_CYCLES == 0) begin
              r_state <= S_SELECT;
            end else begin
              r_timer <= GAP_LOAD;
              r_state <= S_GAP;
            end
          end else if (r_timer == 8'd0) begin
            r_ev    <= 1'b0;
            r_coin  <= 2'b00;
            r_jam   <= 1'b1;
            r_state <= S_JAM;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_GAP: begin
          r_rem <= w_rem_upd;
          if (r_timer == 8'd0) r_state <= S_SELECT;
          else                 r_timer <= r_timer - 8'd1;
        end
        S_DONE: begin
          // A late request is folded into this payout; done only fires once it is all paid.
          if (w_req_nz) begin
            r_rem   <= change_amt;
            r_state <= S_SELECT;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_JAM: begin
          r_rem <= w_rem_upd;
          if (jam_clr) begin
            r_jam   <= 1'b0;
            r_state <= S_SELECT;
          end
        end
        default: begin
          r_ev    <= 1'b0;
          r_coin  <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LOW_COIN_WARN_EN
  localparam logic [3:0] LOW_T = 4'(LOW_THRESH);
  logic r_low;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_low <= 1'b0;
    else          r_low <= (r_cnt5 < LOW_T) || (r_cnt10 < LOW_T) || (r_cnt20 < LOW_T);
  end

  assign low_coin = r_low;
`else
  assign low_coin = 1'b0;
`endif

  assign eject_valid  = r_ev;
  assign eject_coin   = r_coin;
  assign busy         = r_busy;
  assign done         = r_done;
  assign short_change = r_short;
  assign short_amt    = r_samt;
  assign jam          = r_jam;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, multi-cycle corner sequences,
// and randomized payouts checked against a greedy-arithmetic model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       change_req = 1'b0;
  logic [7:0] change_amt = 8'd0;
  logic       hopper_ack = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_coin = 2'b00;
  logic       jam_clr = 1'b0;
  logic       eject_valid;
  logic [1:0] eject_coin;
  logic       busy, done, short_change, jam, low_coin;
  logic [7:0] short_amt;

  change_dispenser dut (
    .clk(clk), .reset_n(reset_n), .change_req(change_req), .change_amt(change_amt),
    .hopper_ack(hopper_ack), .refill(refill), .refill_coin(refill_coin), .jam_clr(jam_clr),
    .eject_valid(eject_valid), .eject_coin(eject_coin), .busy(busy), .done(done),
    .short_change(short_change), .short_amt(short_amt), .jam(jam), .low_coin(low_coin)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int got[$];
  int done_cnt = 0;
  int short_cnt = 0;
  int last_samt = 0;
  bit hop_en = 1'b1;
  int hop_max = 3;
  int hop_wait = 0;
  int m20, m10, m5;

  function automatic int cval(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 20;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (short_change) begin
      short_cnt++;
      last_samt = int'(short_amt);
    end
  end

  // Hopper: accepts each offered coin after a random delay with a one-cycle ack.
  always @(negedge clk) begin
    if (hopper_ack) hopper_ack = 1'b0;
    else if (hop_en && eject_valid) begin
      if (hop_wait == 0) begin
        hopper_ack = 1'b1;
        got.push_back(cval(eject_coin));
        hop_wait = $urandom_range(0, hop_max);
      end else hop_wait--;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m20 = 3; m10 = 3; m5 = 3;
  endtask

  task automatic build(input int n20, input int n10, input int n5, output int q[$]);
    q.delete();
    for (int i = 0; i < n20; i++) q.push_back(20);
    for (int i = 0; i < n10; i++) q.push_back(10);
    for (int i = 0; i < n5; i++)  q.push_back(5);
  endtask

  task automatic pulse_req(input logic [7:0] amt);
    @(negedge clk);
    change_amt = amt;
    change_req = 1'b1;
    @(negedge clk);
    change_req = 1'b0;
  endtask

  task automatic do_refill(input logic [1:0] c);
    @(negedge clk);
    refill_coin = c;
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
  endtask

  task automatic wait_end(input string name, input int d0, input int s0);
    int k;
    for (k = 0; k < 4000; k++) begin
      if (done_cnt != d0 || short_cnt != s0) break;
      @(negedge clk);
    end
    if (k >= 4000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done/short pulse, expected one within 4000 cycles", name);
    end
  endtask

  task automatic wait_ev(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      if (eject_valid) break;
      @(negedge clk);
    end
    if (k >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_ev_timeout: got eject_valid=0, expected 1 within 50 cycles", name);
    end
  endtask

  task automatic check_result(input string name, input int g0, input int d0, input int s0,
                              input int exp_q[$], input int exp_done, input int exp_short,
                              input int exp_samt);
    chk({name, "_ncoins"}, got.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got.size()) chk($sformatf("%s_coin%0d", name, i), got[g0 + i], exp_q[i]);
    chk({name, "_done"}, done_cnt - d0, exp_done);
    chk({name, "_short"}, short_cnt - s0, exp_short);
    if (exp_short != 0) chk({name, "_samt"}, last_samt, exp_samt);
    chk({name, "_idle"}, {busy, eject_valid, eject_coin}, 0);
  endtask

  task automatic run_and_check(input string name, input logic [7:0] amt, input int exp_q[$],
                               input int exp_done, input int exp_short, input int exp_samt);
    int g0, d0, s0;
    g0 = got.size(); d0 = done_cnt; s0 = short_cnt;
    pulse_req(amt);
    if (exp_done + exp_short > 0) wait_end(name, d0, s0);
    repeat (4) @(negedge clk);
    check_result(name, g0, d0, s0, exp_q, exp_done, exp_short, exp_samt);
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] amt;
    int         n20, n10, n5;
    int         exp_short;
    int         samt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int q[$];
    int g0, d0, s0, cnt, exp_low, amt, rem, nr, code;

    vecs[0]  = '{1'b1, 8'd35,  1, 1, 1, 0, 0};
    vecs[1]  = '{1'b1, 8'd20,  1, 0, 0, 0, 0};
    vecs[2]  = '{1'b0, 8'd20,  1, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 8'd20,  1, 0, 0, 0, 0};
    vecs[4]  = '{1'b0, 8'd40,  0, 3, 2, 0, 0};
    vecs[5]  = '{1'b0, 8'd7,   0, 0, 1, 1, 2};
    vecs[6]  = '{1'b0, 8'd5,   0, 0, 0, 1, 5};
    vecs[7]  = '{1'b1, 8'd4,   0, 0, 0, 1, 4};
    vecs[8]  = '{1'b0, 8'd60,  3, 0, 0, 0, 0};
    vecs[9]  = '{1'b0, 8'd255, 0, 3, 3, 1, 210};
    vecs[10] = '{1'b1, 8'd45,  2, 0, 1, 0, 0};
    vecs[11] = '{1'b0, 8'd0,   0, 0, 0, 0, 0};

    reset_n = 1'b0;
    #3;
    chk("reset_outs", {eject_valid, eject_coin, busy, done, short_change, short_amt, jam}, 0);
    chk("reset_low_coin", low_coin, 0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) do_reset();
      build(vecs[i].n20, vecs[i].n10, vecs[i].n5, q);
      run_and_check($sformatf("vec%0d", i), vecs[i].amt, q,
                    (vecs[i].exp_short == 0 && vecs[i].amt != 0) ? 1 : 0,
                    vecs[i].exp_short, vecs[i].samt);
    end

    // Request arriving while the first coin is still waiting for the hopper.
    do_reset();
    hop_en = 1'b0;
    g0 = got.size(); d0 = done_cnt; s0 = short_cnt;
    pulse_req(8'd20);
    wait_ev("accum");
    chk("accum_first_coin", eject_coin, 2'b11);
    pulse_req(8'd10);
    hop_en = 1'b1;
    wait_end("accum", d0, s0);
    repeat (4) @(negedge clk);
    build(1, 1, 0, q);
    check_result("accum", g0, d0, s0, q, 1, 0, 0);

    // Hopper jam, recovery with jam_clr.
    do_reset();
    hop_en = 1'b0;
    g0 = got.size(); d0 = done_cnt; s0 = short_cnt;
    pulse_req(8'd15);
    wait_ev("jam");
    chk("jam_coin", eject_coin, 2'b10);
    cnt = 0;
    while (eject_valid && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("jam_wait_cycles", cnt, 16);
    chk("jam_flag", jam, 1);
    chk("jam_ev_coin", {eject_valid, eject_coin}, 0);
    repeat (5) @(negedge clk);
    chk("jam_sticky", {jam, busy}, 2'b11);
    hop_en = 1'b1;
    jam_clr = 1'b1;
    @(negedge clk);
    jam_clr = 1'b0;
    chk("jam_cleared", jam, 0);
    wait_end("jam", d0, s0);
    repeat (4) @(negedge clk);
    build(0, 1, 1, q);
    check_result("jam", g0, d0, s0, q, 1, 0, 0);

    // Tube20 refills saturate at 15; code 00 does nothing.
    do_reset();
    for (int i = 0; i < 16; i++) do_refill(2'b11);
    do_refill(2'b00);
    build(12, 1, 1, q);
    run_and_check("sat_a", 8'd255, q, 1, 0, 0);
    build(3, 2, 2, q);
    run_and_check("sat_b", 8'd255, q, 0, 1, 165);

    // Reset in the middle of an eject abandons it and restores tubes.
    do_reset();
    build(2, 0, 0, q);
    run_and_check("rst_pre", 8'd40, q, 1, 0, 0);
    hop_en = 1'b0;
    pulse_req(8'd20);
    wait_ev("rst_mid");
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ev", eject_valid, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hop_en = 1'b1;
    build(3, 0, 0, q);
    run_and_check("rst_post", 8'd60, q, 1, 0, 0);

    // Low-coin warning after draining tube5 to one coin.
    do_reset();
    @(negedge clk);
    chk("low_init", low_coin, 0);
    build(0, 0, 1, q);
    run_and_check("low_a", 8'd5, q, 1, 0, 0);
    run_and_check("low_b", 8'd5, q, 1, 0, 0);
`ifdef LOW_COIN_WARN_EN
    exp_low = 1;
`else
    exp_low = 0;
`endif
    chk("low_drained", low_coin, exp_low);

    // Randomized payouts against a greedy model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      nr = $urandom_range(0, 2);
      for (int r = 0; r < nr; r++) begin
        code = $urandom_range(0, 3);
        do_refill(2'(code));
        if (code == 1 && m5 < 15)  m5++;
        if (code == 2 && m10 < 15) m10++;
        if (code == 3 && m20 < 15) m20++;
      end
      amt = $urandom_range(0, 25) * 5;
      if ($urandom_range(0, 3) == 0) amt += $urandom_range(1, 4);
      rem = amt;
      q.delete();
      forever begin
        if (rem >= 20 && m20 > 0)      begin q.push_back(20); rem -= 20; m20--; end
        else if (rem >= 10 && m10 > 0) begin q.push_back(10); rem -= 10; m10--; end
        else if (rem >= 5 && m5 > 0)   begin q.push_back(5);  rem -= 5;  m5--;  end
        else break;
      end
      hop_max = $urandom_range(0, 6);
      run_and_check($sformatf("rnd%0d", it), 8'(amt), q,
                    (amt != 0 && rem == 0) ? 1 : 0, (rem != 0) ? 1 : 0, rem);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
